// File: rtl/data_mem_unit_if.sv
// Memory-stage bus between the pipeline M stage and the data memory unit.
// The pipeline drives the request fields; the memory unit returns load data,
// the hazard stall and the misalignment flag.
interface data_mem_if;
    logic        i_MemWriteM;
    logic        i_MemReadM;
    logic [1:0]  i_RAM_selM;
    logic [2:0]  i_MemDataSelM;
    logic [31:0] i_AddrM;
    logic [31:0] i_WriteDataM;
    logic [31:0] o_ReadDataM;
    logic        o_StallM;
    logic        o_MisalignM;

    modport master (
        output i_MemWriteM, i_MemReadM, i_RAM_selM, i_MemDataSelM, i_AddrM, i_WriteDataM,
        input  o_ReadDataM, o_StallM, o_MisalignM
    );

    modport slave (
        input  i_MemWriteM, i_MemReadM, i_RAM_selM, i_MemDataSelM, i_AddrM, i_WriteDataM,
        output o_ReadDataM, o_StallM, o_MisalignM
    );
endinterface

// File: rtl/data_mem_unit.sv
// Data memory responder for the M stage: word/half/byte stores and
// sign/zero-extended loads on a word-organised RAM with configurable wait
// states. The RAM is split into four byte-lane arrays so each lane maps onto
// a plain block RAM with its own write enable.
module data_mem_unit #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;
    logic [1:0]            lo_reg;
    logic [31:0]           wdata_reg;
    logic [3:0]            be_reg;
    logic [2:0]            fmt_reg;
    logic                  write_reg;
    logic                  read_reg;
    logic [3:0][7:0]       rd_word;

    logic        any_access;
    logic        is_half;
    logic        is_byte;
    logic        misalign;
    logic        req;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        fire;
    logic        wr_fire;
    logic        rd_fire;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    // Upper address bits are deliberately ignored: addresses wrap modulo the RAM depth.
    logic unused_addr;
    assign unused_addr = ^bus.i_AddrM[31:ADDR_WIDTH+2];

    // Decode the access size (store size wins when a write is present), lane enables and lane data.
    always_comb begin
        any_access = bus.i_MemWriteM | bus.i_MemReadM;
        is_half    = 1'b0;
        is_byte    = 1'b0;
        if (bus.i_MemWriteM) begin
            is_half = (bus.i_RAM_selM == 2'b01);
            is_byte = (bus.i_RAM_selM == 2'b10);
        end else begin
            is_half = (bus.i_MemDataSelM == 3'b001) || (bus.i_MemDataSelM == 3'b010);
            is_byte = (bus.i_MemDataSelM == 3'b011) || (bus.i_MemDataSelM == 3'b100);
        end
        misalign = any_access &
                   ((~is_half & ~is_byte & (bus.i_AddrM[1:0] != 2'b00)) |
                    (is_half & bus.i_AddrM[0]));
        req = any_access & ~misalign;
        if (is_byte) begin
            be_next    = 4'b0001 << bus.i_AddrM[1:0];
            wdata_next = {4{bus.i_WriteDataM[7:0]}};
        end else if (is_half) begin
            be_next    = bus.i_AddrM[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{bus.i_WriteDataM[15:0]}};
        end else begin
            be_next    = 4'b1111;
            wdata_next = bus.i_WriteDataM;
        end
    end

    assign fire    = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
    assign wr_fire = fire & write_reg;
    assign rd_fire = fire & read_reg & ~write_reg;

    // Access sequencer: latch the request, count wait states, then present the response for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            read_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        idx_reg   <= bus.i_AddrM[ADDR_WIDTH+1:2];
                        lo_reg    <= bus.i_AddrM[1:0];
                        wdata_reg <= wdata_next;
                        be_reg    <= be_next;
                        fmt_reg   <= bus.i_MemDataSelM;
                        write_reg <= bus.i_MemWriteM;
                        read_reg  <= bus.i_MemReadM;
                        cnt_reg   <= 4'(WAIT_CYCLES);
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // One block RAM per byte lane; a reset edge coinciding with the write slot drops the write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            // Lane write port.
            always_ff @(posedge clk) begin
                if (rst_n && wr_fire && be_reg[gi]) begin
                    lane_mem[idx_reg] <= wdata_reg[gi*8 +: 8];
                end
            end

            // Registered lane read, cleared by reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_rd_reg <= 8'd0;
                end else if (rd_fire) begin
                    lane_rd_reg <= lane_mem[idx_reg];
                end
            end

            assign rd_word[gi] = lane_rd_reg;
        end
    endgenerate

    // Extract and extend the loaded field from the latched word.
    always_comb begin
        sel_byte = rd_word[lo_reg];
        sel_half = lo_reg[1] ? rd_word[3:2] : rd_word[1:0];
        case (fmt_reg)
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_ext = {16'd0, sel_half};
            3'b011:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'd0, sel_byte};
            default: load_ext = rd_word;
        endcase
    end

    assign bus.o_ReadDataM = ((state_reg == ST_RESP) && read_reg && !write_reg) ? load_ext : 32'd0;
    assign bus.o_StallM    = req & (state_reg != ST_RESP);
    assign bus.o_MisalignM = misalign;
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: three instances with WAIT_CYCLES = 1, 3 and 0,
// directed scenarios plus randomized traffic checked against a byte-level model.
module tb_data_mem_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        mw    [3];
    logic        mr    [3];
    logic [1:0]  sel   [3];
    logic [2:0]  fmt   [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rd_o  [3];
    logic        st_o  [3];
    logic        mis_o [3];
    logic        rst_n [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 1 : (gi == 1) ? 3 : 0;
            data_mem_if bus ();
            assign bus.i_MemWriteM   = mw[gi];
            assign bus.i_MemReadM    = mr[gi];
            assign bus.i_RAM_selM    = sel[gi];
            assign bus.i_MemDataSelM = fmt[gi];
            assign bus.i_AddrM       = addr[gi];
            assign bus.i_WriteDataM  = wd[gi];
            assign rd_o[gi]  = bus.o_ReadDataM;
            assign st_o[gi]  = bus.o_StallM;
            assign mis_o[gi] = bus.o_MisalignM;
            data_mem_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) dut (
                .clk   (clk),
                .rst_n (rst_n[gi]),
                .bus   (bus)
            );
        end
    endgenerate

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: byte-addressed memory per instance (1024 words = 4096 bytes).
    logic [7:0] bmem [3][4096];
    bit         bval [3][4096];

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    function automatic int acc_bytes(input bit w, input logic [1:0] s, input logic [2:0] f);
        if (w) return (s == 2'd1) ? 2 : (s == 2'd2) ? 1 : 4;
        return (f == 3'd1 || f == 3'd2) ? 2 : (f == 3'd3 || f == 3'd4) ? 1 : 4;
    endfunction

    function automatic bit model_mis(input bit w, input bit r, input logic [1:0] s,
                                     input logic [2:0] f, input logic [31:0] a);
        if (!(w | r)) return 1'b0;
        return (int'(a[1:0]) % acc_bytes(w, s, f)) != 0;
    endfunction

    task automatic model_store(input int d, input logic [1:0] s, input logic [31:0] a,
                               input logic [31:0] wdata);
        int n = acc_bytes(1'b1, s, 3'd0);
        for (int i = 0; i < n; i++) begin
            int ba = (int'(a[11:0]) + i) % 4096;
            bmem[d][ba] = wdata[8*i +: 8];
            bval[d][ba] = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_load(input int d, input logic [2:0] f,
                                               input logic [31:0] a, output bit ok);
        int n = acc_bytes(1'b0, 2'd0, f);
        logic [31:0] v = 32'd0;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            int ba = (int'(a[11:0]) + i) % 4096;
            if (!bval[d][ba]) ok = 1'b0;
            v = v | (32'(bmem[d][ba]) << (8 * i));
        end
        if (f == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
        if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Present one memory-stage instruction, hold it while stalled, sample the response cycle.
    // Entered and left at 1 time unit after a rising edge.
    task automatic access(input int d, input bit w, input bit r, input logic [1:0] s,
                          input logic [2:0] f, input logic [31:0] a, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int stalls, output bit mis,
                          output int resp_cyc);
        mw[d] = w; mr[d] = r; sel[d] = s; fmt[d] = f; addr[d] = a; wd[d] = wdata;
        #1;
        mis    = mis_o[d];
        stalls = 0;
        while (st_o[d] === 1'b1 && stalls <= 40) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        rdata    = rd_o[d];
        resp_cyc = cyc;
        $display("txn dut%0d w=%0b r=%0b sel=%0d fmt=%0d addr=%h wdata=%h -> rd=%h stall=%0d mis=%0b",
                 d, w, r, s, f, a, wdata, rdata, stalls, mis);
        @(posedge clk);
        #1;
        mw[d] = 1'b0; mr[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; mw[d] = 1'b0; mr[d] = 1'b0; sel[d] = 2'd0; fmt[d] = 3'd0;
            addr[d] = 32'd0; wd[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (st_o[d] !== 1'b0) begin
                n_err++; $display("FAIL reset_stall dut%0d: got %b expected 0", d, st_o[d]);
            end
            n_cmp++;
            if (rd_o[d] !== 32'd0) begin
                n_err++; $display("FAIL reset_rdata dut%0d: got %h expected 0", d, rd_o[d]);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    endtask

    task automatic test_word_round_trip();
        logic [31:0] rd; int st; bit mis; int rc;
        access(0, 1, 0, 2'd0, 3'd0, 32'h40, 32'hDEAD_BEEF, rd, st, mis, rc);
        model_store(0, 2'd0, 32'h40, 32'hDEAD_BEEF);
        n_cmp++;
        if (st !== 3) begin n_err++; $display("FAIL sw_stall: got %0d cycles expected 3", st); end
        access(0, 0, 1, 2'd0, 3'd0, 32'h40, 32'd0, rd, st, mis, rc);
        n_cmp++;
        if (st !== 3) begin n_err++; $display("FAIL lw_stall: got %0d cycles expected 3", st); end
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_half_merge();
        logic [31:0] rd; int st; bit mis; int rc;
        access(0, 1, 0, 2'd0, 3'd0, 32'h80, 32'h1122_3344, rd, st, mis, rc);
        model_store(0, 2'd0, 32'h80, 32'h1122_3344);
        access(0, 1, 0, 2'd2, 3'd0, 32'h81, 32'h0000_00AA, rd, st, mis, rc);
        model_store(0, 2'd2, 32'h81, 32'h0000_00AA);
        access(0, 1, 0, 2'd1, 3'd0, 32'h82, 32'h0000_BBCC, rd, st, mis, rc);
        model_store(0, 2'd1, 32'h82, 32'h0000_BBCC);
        access(0, 0, 1, 2'd0, 3'd0, 32'h80, 32'd0, rd, st, mis, rc);
        n_cmp++;
        if (rd !== 32'hBBCC_AA44) begin n_err++; $display("FAIL merge_lw: got %h expected bbccaa44", rd); end
    endtask

    task automatic test_extension();
        logic [31:0] rd; int st; bit mis; int rc;
        logic [2:0]  fmts [5] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd2};
        logic [31:0] adrs [5] = '{32'h12, 32'h13, 32'h11, 32'h12, 32'h12};
        logic [31:0] exps [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF};
        access(0, 1, 0, 2'd0, 3'd0, 32'h10, 32'h80FF_7F01, rd, st, mis, rc);
        model_store(0, 2'd0, 32'h10, 32'h80FF_7F01);
        for (int i = 0; i < 5; i++) begin
            access(0, 0, 1, 2'd0, fmts[i], adrs[i], 32'd0, rd, st, mis, rc);
            n_cmp++;
            if (rd !== exps[i]) begin
                n_err++; $display("FAIL ext_load%0d fmt=%0d addr=%h: got %h expected %h", i, fmts[i], adrs[i], rd, exps[i]);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; int st; bit mis; int rc;
        access(0, 0, 1, 2'd0, 3'd0, 32'h42, 32'd0, rd, st, mis, rc);
        n_cmp++;
        if (mis !== 1'b1 || st !== 0 || rd !== 32'd0) begin
            n_err++; $display("FAIL mis_lw: got mis=%b stall=%0d rd=%h expected 1/0/0", mis, st, rd);
        end
        access(0, 1, 0, 2'd1, 3'd0, 32'h43, 32'h0000_9999, rd, st, mis, rc);
        n_cmp++;
        if (mis !== 1'b1 || st !== 0 || rd !== 32'd0) begin
            n_err++; $display("FAIL mis_sh: got mis=%b stall=%0d rd=%h expected 1/0/0", mis, st, rd);
        end
        access(0, 0, 1, 2'd0, 3'd0, 32'h40, 32'd0, rd, st, mis, rc);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || st !== 3) begin
            n_err++; $display("FAIL mis_after_lw: got rd=%h stall=%0d expected deadbeef/3", rd, st);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; int st; bit mis; int rc;
        access(0, 1, 0, 2'd0, 3'd0, 32'h1004, 32'h5A5A_5A5A, rd, st, mis, rc);
        model_store(0, 2'd0, 32'h1004, 32'h5A5A_5A5A);
        access(0, 0, 1, 2'd0, 3'd0, 32'h0004, 32'd0, rd, st, mis, rc);
        n_cmp++;
        if (rd !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL wrap_lw: got %h expected 5a5a5a5a", rd); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; int st; bit mis; int rc;
        access(1, 1, 0, 2'd0, 3'd0, 32'h20, 32'hCAFE_F00D, rd, st, mis, rc);
        model_store(1, 2'd0, 32'h20, 32'hCAFE_F00D);
        n_cmp++;
        if (st !== 5) begin n_err++; $display("FAIL w3_sw_stall: got %0d cycles expected 5", st); end
        // Store request; reset lands on the edge that would perform the write (cycle 4).
        mw[1] = 1'b1; mr[1] = 1'b0; sel[1] = 2'd0; fmt[1] = 3'd0; addr[1] = 32'h20; wd[1] = 32'h1234_5678;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (st_o[1] !== 1'b1) begin n_err++; $display("FAIL w3_stall_c4: got %b expected 1", st_o[1]); end
        rst_n[1] = 1'b0; mw[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        #1;
        n_cmp++;
        if (st_o[1] !== 1'b0 || rd_o[1] !== 32'd0) begin
            n_err++; $display("FAIL midreset_idle: got stall=%b rd=%h expected 0/0", st_o[1], rd_o[1]);
        end
        @(posedge clk);
        #1;
        access(1, 0, 1, 2'd0, 3'd0, 32'h20, 32'd0, rd, st, mis, rc);
        n_cmp++;
        if (rd !== 32'hCAFE_F00D || st !== 5) begin
            n_err++; $display("FAIL midreset_lw: got rd=%h stall=%0d expected cafef00d/5", rd, st);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int st; bit mis; int rc; int c0;
        logic [31:0] vals [3] = '{32'h0BAD_F00D, 32'h7777_0001, 32'hF0E1_D2C3};
        for (int i = 0; i < 3; i++) begin
            access(2, 1, 0, 2'd0, 3'd0, 32'h300 + 32'(4 * i), vals[i], rd, st, mis, rc);
            model_store(2, 2'd0, 32'h300 + 32'(4 * i), vals[i]);
        end
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            access(2, 0, 1, 2'd0, 3'd0, 32'h300 + 32'(4 * i), 32'd0, rd, st, mis, rc);
            n_cmp++;
            if (st !== 2 || rd !== vals[i] || (rc - c0) !== 2 + 3 * i) begin
                n_err++; $display("FAIL b2b_lw%0d: got stall=%0d rd=%h resp_cycle=%0d expected 2/%h/%0d",
                                  i, st, rd, rc - c0, vals[i], 2 + 3 * i);
            end
        end
    endtask

    task automatic test_random(input int d);
        logic [31:0] rd; int st; bit mis; int rc;
        logic [31:0] a, wdata, exp_rd, tmp;
        bit w, r, exp_mis, ok;
        logic [1:0] s; logic [2:0] f;
        int kind, exp_st;
        for (int i = 0; i < 16; i++) begin
            wdata = $urandom();
            access(d, 1, 0, 2'd0, 3'd0, 32'h200 + 32'(4 * i), wdata, rd, st, mis, rc);
            model_store(d, 2'd0, 32'h200 + 32'(4 * i), wdata);
        end
        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(0, 10);
            w     = (kind <= 3) || (kind == 9);
            r     = (kind >= 4) && (kind <= 9);
            s     = 2'($urandom_range(0, 3));
            f     = 3'($urandom_range(0, 7));
            tmp   = $urandom();
            a     = {tmp[31:12], 12'(32'h200 + $urandom_range(0, 63))};
            wdata = $urandom();
            exp_mis = model_mis(w, r, s, f, a);
            exp_st  = (exp_mis || !(w | r)) ? 0 : wait_of(d) + 2;
            exp_rd  = 32'd0;
            ok      = 1'b1;
            if (r && !w && !exp_mis) exp_rd = model_load(d, f, a, ok);
            access(d, w, r, s, f, a, wdata, rd, st, mis, rc);
            n_cmp++;
            if (mis !== exp_mis || st !== exp_st || (ok && rd !== exp_rd)) begin
                n_err++; $display("FAIL rand dut%0d #%0d addr=%h: got mis=%b stall=%0d rd=%h expected %b/%0d/%h",
                                  d, i, a, mis, st, rd, exp_mis, exp_st, exp_rd);
            end
            if (w && !exp_mis) model_store(d, s, a, wdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_round_trip();
        test_byte_half_merge();
        test_extension();
        test_misalign();
        test_wrap();
        test_reset_mid_access();
        test_back_to_back();
        test_random(0);
        test_random(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Memory-stage responder for the pipelined MIPS core. It consumes the store-size select (RAM_sel) and load-format select (MemDataSelD) control fields after they are pipelined to the M stage, and performs word, half and byte accesses on an internal word-organised data RAM. Sub-word loads are sign- or zero-extended. A stall is raised toward the hazard unit while the RAM's configurable wait states elapse.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, extra RAM wait states per access (0..15).
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_MemWriteM  in  1  store request.
- i_MemReadM  in  1  load request (decoder memtoreg == 01).
- i_RAM_selM  in  2  store size: 00 word, 01 half, 10 byte, 11 treated as word.
- i_MemDataSelM  in  3  load format: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others treated as LW.
- i_AddrM  in  32  byte address from the ALU.
- i_WriteDataM  in  32  store data; low bits are used for sub-word stores.
- o_ReadDataM  out  32  extended load result; valid in the RESP state, 0 otherwise.
- o_StallM  out  1  freezes PC, IF/ID, ID/EX and EX/M registers and bubbles M/W.
- o_MisalignM  out  1  combinational misaligned-access flag.

## Operation
- Request: `req = (i_MemWriteM | i_MemReadM) & ~o_MisalignM`.
- Misaligned access:
  - Word access with addr[1:0] != 0, or half access with addr[0] = 1, sets o_MisalignM = 1.
  - Nothing is written, no stall is raised, and o_ReadDataM = 0.
- Word index: i_AddrM[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM depth.
- Byte lanes are little-endian: lane k = bits [8k+7:8k] at addr[1:0] = k.
  - Byte store writes WriteData[7:0] to lane addr[1:0].
  - Half store writes WriteData[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all four lanes.
  - Unselected lanes are preserved.
- Load extraction uses the latched word and latched addr[1:0]:
  - LB/LBU select the byte; LH/LHU select the half at addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- If write and read are asserted together, the write is performed and o_ReadDataM = 0.
- FSM states:
  - IDLE:
    - On req: latch address, data, size and format; load cnt = WAIT_CYCLES; go to WAIT.
    - Without req: stay in IDLE.
  - WAIT:
    - If cnt == 0: perform the array write, or read the addressed word into rd_word; go to RESP.
    - Otherwise: cnt decrements.
  - RESP: unconditionally go to IDLE on the next edge.
- o_StallM = req & (state != RESP). It is combinational, so it is high in the same cycle a request first appears.
- Request inputs must stay stable while stalled; the pipeline guarantees this. The unit uses only the latched copies.
- Array contents are not reset (contents after reset are undefined; the bench initialises them by stores).

## Timing
- Reset (rst_n = 0 at an edge): state = IDLE, cnt = 0, rd_word = 0.
  - o_StallM = 0, o_ReadDataM = 0. o_MisalignM follows its inputs.
- Reset mid-access (WAIT or RESP): return to IDLE; a pending write is dropped and not performed.
- Access timeline, with the request first seen in cycle 0:
  - o_StallM is high for cycles 0 .. WAIT_CYCLES+1.
  - The array write/read happens at the end of cycle WAIT_CYCLES+1.
  - The RESP cycle is WAIT_CYCLES+2: o_StallM = 0 and o_ReadDataM is valid; the M/W register captures it at that edge.
- Total latency: WAIT_CYCLES+3 cycles per memory instruction. WAIT_CYCLES = 0 gives 2 stall cycles.
- Back-to-back memory instructions: the following request is first seen in the cycle after RESP, with no overlap. Throughput is one access per WAIT_CYCLES+3 cycles.
- Non-memory instructions: zero stall, and the FSM stays in IDLE.
- A store followed immediately by a load to the same word returns the newly written data.

## Test plan
- Word round trip:
  - SW 0xDEADBEEF to 0x40, then LW 0x40 with WAIT_CYCLES = 1.
  - Required: o_StallM high exactly 3 cycles per access; o_ReadDataM = 0xDEADBEEF in the RESP cycle.
- Byte/half merge:
  - SW 0x11223344 to 0x80, SB 0xAA to 0x81, SH 0xBBCC to 0x82.
  - Required: LW 0x80 returns 0xBBCCAA44.
- Extension:
  - Store word 0x80FF7F01 to 0x10.
  - Required: LB 0x12 = 0xFFFFFFFF; LBU 0x13 = 0x00000080; LB 0x11 = 0x0000007F; LH 0x12 = 0xFFFF80FF; LHU 0x12 = 0x000080FF.
- Misalignment:
  - LW 0x42, SH 0x43.
  - Required: o_MisalignM = 1, o_StallM = 0, FSM stays in IDLE. A following LW 0x40 still returns the prior contents.
- Wrap and reset:
  - With ADDR_WIDTH = 10, SW 0x5A5A5A5A to 0x1004, then LW 0x0004 returns 0x5A5A5A5A.
  - SW 0x12345678 to 0x20, with rst_n pulsed low during WAIT (WAIT_CYCLES = 3): state returns to IDLE, o_StallM = 0, and LW 0x20 returns the old value.
- Back-to-back:
  - Three consecutive LW instructions with WAIT_CYCLES = 0.
  - Required: each stalls exactly 2 cycles; results appear in RESP cycles 2, 5 and 8.
